// File: rtl/prod_acc_pkg.sv
// Shared definitions for the product accumulator.
//   acc_state_e : FSM encoding (IDLE, ACC, HOLD)
//   Def*        : default widths/length used by prod_accumulator parameters
package prod_acc_pkg;

    localparam int unsigned DefProdW = 8;
    localparam int unsigned DefAccW  = 16;
    localparam int unsigned DefLen   = 4;

    // ACC_HOLD (partial group while a result is held) has no encoding: input
    // is stalled whenever a result is held and not being taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/prod_accumulator.sv
// Accumulates groups of unsigned products into dot-product results.
// A group closes after LEN beats or on a beat flagged in_last; the result is
// presented on a registered valid/ready output with beat count and a sticky
// carry-out flag.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     product beat handshake
//   in_prod               unsigned product (PROD_W)
//   in_last               closes the group early (qualified by in_valid)
//   out_valid/out_ready   result handshake
//   out_sum               group sum mod 2^ACC_W
//   out_count             beats in the group (1..LEN)
//   out_ovf               at least one carry out of ACC_W in the group
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int unsigned PROD_W = DefProdW,
    parameter int unsigned ACC_W  = DefAccW,
    parameter int unsigned LEN    = DefLen,
    localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LenCnt = CNT_W'(LEN);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             take;
    logic             final_beat;
    logic             carry;
    logic [ACC_W:0]   sum_wide;
    logic [CNT_W-1:0] cnt_inc;

    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // Depends only on the output side so no combinational path runs from the
    // product inputs back to in_ready.
    assign in_ready = !rst && (!out_valid || out_ready);

    assign accept     = in_valid && in_ready;
    assign take       = out_valid && out_ready;
    assign sum_wide   = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);
    assign carry      = sum_wide[ACC_W];
    assign cnt_inc    = cnt_q + 1'b1;
    assign final_beat = (cnt_inc == LenCnt) || in_last;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            if (final_beat) begin
                // Overwrites any result being taken this cycle: no bubble.
                out_sum_d   = sum_wide[ACC_W-1:0];
                out_count_d = cnt_inc;
                out_ovf_d   = ovf_acc_q || carry;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_acc_d   = 1'b0;
                state_d     = HOLD;
            end else begin
                acc_d     = sum_wide[ACC_W-1:0];
                cnt_d     = cnt_inc;
                ovf_acc_d = ovf_acc_q || carry;
                state_d   = ACC;
            end
        end else if (take) begin
            // Result fields are kept; only the valid state drops.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
